// File: rtl/uart_debug_poller.sv
// uart_debug_poller: Wishbone master that polls UART debug words 0x08/0x0C into a host-visible snapshot
// and flags any change between consecutive polls.
module uart_debug_poller #(
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 5,
   parameter int POLL_DIV = 1024,
   parameter int TIMEOUT  = 15
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              en_i,
   input  logic              trig_i,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   input  logic [31:0]       wbm_dat_i,
   input  logic              wbm_ack_i,
   output logic [31:0]       snap0_o,
   output logic [31:0]       snap1_o,
   output logic [7:0]        lsr_o,
   output logic [7:0]        msr_o,
   output logic [7:0]        lcr_o,
   output logic [CNT_W-1:0]  rf_count_o,
   output logic [CNT_W-1:0]  tf_count_o,
   output logic [3:0]        rstate_o,
   output logic [2:0]        tstate_o,
   output logic [63:0]       diff_o,
   output logic              change_o,
   output logic              done_o,
   output logic              busy_o,
   output logic              tmo_err_o,
   output logic [15:0]       sample_cnt_o
);
   localparam logic [2:0] IDLE = 3'd0, RD0 = 3'd1, GAP = 3'd2, RD1 = 3'd3, CMP = 3'd4;
   localparam int PW = $clog2(POLL_DIV);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] A0 = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A1 = ADDR_W'(8'h0C);

   logic [2:0]    state;
   logic [PW-1:0] icnt;
   logic [TW-1:0] wcnt;
   logic          pending;
   logic [31:0]   sh0, sh1;
   logic          start, tmo;

   assign start = (state == IDLE) && (trig_i || pending || (en_i && icnt == PW'(POLL_DIV - 1)));
   assign tmo = wcnt == TW'(TIMEOUT - 1);
   assign busy_o = state != IDLE;
   assign wbm_we_o = 1'b0;

   assign lsr_o      = snap0_o[7:0];
   assign lcr_o      = snap0_o[23:16];
   assign msr_o      = snap0_o[31:24];
   assign tstate_o   = snap1_o[2:0];
   assign tf_count_o = snap1_o[3 +: CNT_W];
   assign rstate_o   = snap1_o[3 + CNT_W +: 4];
   assign rf_count_o = snap1_o[7 + CNT_W +: CNT_W];

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state        <= IDLE;
         icnt         <= '0;
         wcnt         <= '0;
         pending      <= 1'b0;
         sh0          <= '0;
         sh1          <= '0;
         wbm_adr_o    <= '0;
         wbm_cyc_o    <= 1'b0;
         wbm_stb_o    <= 1'b0;
         wbm_sel_o    <= '0;
         snap0_o      <= '0;
         snap1_o      <= '0;
         diff_o       <= '0;
         change_o     <= 1'b0;
         done_o       <= 1'b0;
         tmo_err_o    <= 1'b0;
         sample_cnt_o <= '0;
      end else begin
         done_o   <= 1'b0;
         change_o <= 1'b0;
         icnt     <= (!en_i || start) ? '0 : (state == IDLE) ? icnt + 1'b1 : icnt;
         // one queued request at most; the poll that consumes it clears it
         pending  <= (busy_o && trig_i) || (pending && !start);
         case (state)
            IDLE: if (start) begin
               state     <= RD0;
               wbm_cyc_o <= 1'b1;
               wbm_stb_o <= 1'b1;
               wbm_sel_o <= 4'hF;
               wbm_adr_o <= A0;
               wcnt      <= '0;
            end
            RD0, RD1: if (wbm_ack_i) begin
               if (state == RD0) sh0 <= wbm_dat_i;
               else sh1 <= wbm_dat_i;
               state     <= (state == RD0) ? GAP : CMP;
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               wbm_sel_o <= '0;
            end else if (tmo) begin
               state     <= IDLE;
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               wbm_sel_o <= '0;
               tmo_err_o <= 1'b1;
            end else begin
               wcnt <= wcnt + 1'b1;
            end
            GAP: begin
               state     <= RD1;
               wbm_cyc_o <= 1'b1;
               wbm_stb_o <= 1'b1;
               wbm_sel_o <= 4'hF;
               wbm_adr_o <= A1;
               wcnt      <= '0;
            end
            CMP: begin
               state        <= IDLE;
               snap0_o      <= sh0;
               snap1_o      <= sh1;
               diff_o       <= {sh1 ^ snap1_o, sh0 ^ snap0_o};
               change_o     <= (sh0 != snap0_o) || (sh1 != snap1_o);
               done_o       <= 1'b1;
               sample_cnt_o <= sample_cnt_o + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_debug_poller.sv
// tb_uart_debug_poller: randomized bench with a transaction-level model of the poller, a per-cycle
// compare process and directed literal cases for latency, period, timeout, pending and reset.
module tb_uart_debug_poller;
   localparam int TO = 15;
   localparam int PD = 16;

   logic        clk = 1'b0;
   logic        rst_n, en, trig;
   logic [4:0]  adr;
   logic        cyc, stb, we, ack;
   logic [3:0]  sel;
   logic [31:0] dat, s0, s1;
   logic [7:0]  lsr, msr, lcr;
   logic [4:0]  rfc, tfc;
   logic [3:0]  rst_s;
   logic [2:0]  tst;
   logic [63:0] diff;
   logic        chg, done, busy, tmo;
   logic [15:0] scnt;

   logic [4:0]  swc;
   int          lat;
   logic        never1;
   logic [31:0] w0, w1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_debug_poller #(.ADDR_W(5), .CNT_W(5), .POLL_DIV(PD), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .en_i(en), .trig_i(trig),
      .wbm_adr_o(adr), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_dat_i(dat), .wbm_ack_i(ack),
      .snap0_o(s0), .snap1_o(s1), .lsr_o(lsr), .msr_o(msr), .lcr_o(lcr),
      .rf_count_o(rfc), .tf_count_o(tfc), .rstate_o(rst_s), .tstate_o(tst),
      .diff_o(diff), .change_o(chg), .done_o(done), .busy_o(busy), .tmo_err_o(tmo),
      .sample_cnt_o(scnt)
   );

   // slave: acks after lat wait cycles, optionally never acks 0x0C
   assign ack = cyc && stb && !(never1 && adr == 5'h0C) && (int'(swc) >= lat);
   assign dat = (adr == 5'h08) ? w0 : w1;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) swc <= '0;
      else swc <= (cyc && stb && !ack) ? swc + 5'd1 : 5'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic trig_poll(output int n);
      trig = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         trig = 1'b0;
         n++;
      end while (!done && n < 100);
   endtask

   // model: what the slave returned for the two reads of a poll becomes the next snapshot
   initial begin
      logic [31:0] m0, m1, g0, g1;
      logic [15:0] mc;
      logic mt;
      int ph, wc, gp, p2;
      m0 = '0; m1 = '0; g0 = '0; g1 = '0; mc = '0; mt = 1'b0; ph = 0; wc = 0; gp = 0; p2 = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m0 = '0; m1 = '0; mc = '0; mt = 1'b0; ph = 0; wc = 0; gp = 0; p2 = 0;
         end else begin
            if (wc == TO) begin
               chk("tmo_drop", cyc, 0);
               mt = 1'b1; ph = 0; wc = 0; gp = 0;
            end
            chk("tmo_err", tmo, mt);
            chk("we", we, 0);
            if (gp == 1) begin chk("gap_low", cyc, 0); gp = 2; end
            else if (gp == 2) begin chk("gap_rd1", cyc, 1); gp = 0; end
            if (done) begin
               chk("done_after_reads", ph, 2);
               chk("diff", diff, {g1 ^ m1, g0 ^ m0});
               chk("change", chg, (g1 != m1) || (g0 != m0));
               m0 = g0; m1 = g1; mc = mc + 16'd1; ph = 0;
            end else begin
               chk("change_idle", chg, 0);
               if (ph == 2) begin
                  p2++;
                  if (p2 == 2) begin chk("done_missing", done, 1); ph = 0; end
               end
            end
            if (cyc) begin
               chk("stb", stb, 1);
               chk("sel", sel, 4'hF);
               chk("busy", busy, 1);
               chk("adr", adr, (ph == 0) ? 5'h08 : 5'h0C);
               if (ack) begin
                  if (ph == 0) begin g0 = dat; ph = 1; gp = 1; end
                  else begin g1 = dat; ph = 2; p2 = 0; end
                  wc = 0;
               end else wc++;
            end else begin
               chk("stb_idle", stb, 0);
               chk("sel_idle", sel, 0);
            end
            chk("snap0", s0, m0);
            chk("snap1", s1, m1);
            chk("cnt", scnt, mc);
            chk("lsr", lsr, m0[7:0]);
            chk("lcr", lcr, m0[23:16]);
            chk("msr", msr, m0[31:24]);
            chk("tstate", tst, m1 % 8);
            chk("tf_count", tfc, (m1 >> 3) % 32);
            chk("rstate", rst_s, (m1 >> 8) % 16);
            chk("rf_count", rfc, (m1 >> 12) % 32);
         end
      end
   end

   initial begin
      int n, k, nd, r;
      int st[3];
      logic pc;
      logic [15:0] c0;
      rst_n = 1'b0; en = 1'b0; trig = 1'b0; lat = 0; never1 = 1'b0; w0 = '0; w1 = '0;
      st = '{0, 0, 0};
      repeat (2) @(posedge clk); #1;
      chk("rst_cyc", cyc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_snap0", s0, 0);
      chk("rst_cnt", scnt, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      w0 = 32'h11223344; w1 = 32'h00ABCDEF;
      trig_poll(n);
      chk("t1_latency", n, 5);
      chk("t1_snap0", s0, 32'h11223344);
      chk("t1_snap1", s1, 32'h00ABCDEF);
      chk("t1_change", chg, 1);
      chk("t1_diff", diff, 64'h00ABCDEF_11223344);
      chk("t1_cnt", scnt, 1);
      chk("t1_lsr", lsr, 8'h44);
      chk("t1_lcr", lcr, 8'h22);
      chk("t1_msr", msr, 8'h11);
      chk("t1_tstate", tst, 3'd7);
      chk("t1_tf", tfc, 5'd29);
      chk("t1_rstate", rst_s, 4'd13);
      chk("t1_rf", rfc, 5'd28);

      @(posedge clk); #1;
      trig_poll(n);
      chk("t2_done", done, 1);
      chk("t2_change", chg, 0);
      chk("t2_diff", diff, 0);
      chk("t2_cnt", scnt, 2);

      en = 1'b1; n = 0; k = 0; pc = cyc;
      while (k < 3 && n < 300) begin
         @(negedge clk);
         n++;
         if (cyc && !pc && adr == 5'h08) begin st[k] = n; k++; end
         pc = cyc;
      end
      chk("t3_period1", st[1] - st[0], 20);
      chk("t3_period2", st[2] - st[1], 20);
      en = 1'b0;
      repeat (10) @(posedge clk); #1;

      never1 = 1'b1; c0 = scnt; n = 0; nd = 0;
      trig = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         trig = 1'b0;
         if (done) nd++;
         if (cyc && adr == 5'h0C) n++;
         if (n > 0 && !cyc) break;
      end
      chk("t4_tmo_len", n, 15);
      chk("t4_tmo_err", tmo, 1);
      chk("t4_done", nd, 0);
      chk("t4_cnt", scnt, c0);
      chk("t4_snap0", s0, 32'h11223344);
      never1 = 1'b0;
      repeat (4) @(posedge clk); #1;

      lat = 3; c0 = scnt;
      trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
      chk("t5_busy", busy, 1);
      repeat (3) begin
         @(posedge clk); #1; trig = 1'b1;
         @(posedge clk); #1; trig = 1'b0;
      end
      repeat (60) @(posedge clk); #1;
      chk("t5_cnt", scnt, c0 + 16'd2);
      lat = 0;

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         trig = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 15) == 0) w0 = $urandom;
         if ($urandom_range(0, 15) == 0) w1 = $urandom;
         if (!cyc && $urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 9);
            lat = (r < 6) ? r % 3 : (r == 6) ? 14 : (r == 7) ? 15 : (r == 8) ? 16 : 3;
         end
      end
      trig = 1'b0; en = 1'b0; lat = 0;
      repeat (60) @(posedge clk); #1;

      never1 = 1'b1; n = 0;
      trig = 1'b1;
      do begin
         @(posedge clk); #1;
         trig = 1'b0;
         n++;
      end while (!(cyc && adr == 5'h0C) && n < 100);
      chk("t7_in_rd1", cyc && adr == 5'h0C, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_cyc", cyc, 0);
      chk("t7_stb", stb, 0);
      chk("t7_sel", sel, 0);
      chk("t7_busy", busy, 0);
      chk("t7_snap0", s0, 0);
      chk("t7_cnt", scnt, 0);
      chk("t7_tmo", tmo, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; never1 = 1'b0;
      @(posedge clk); #1;
      chk("t7_idle", busy, 0);
      trig_poll(n);
      chk("t7_poll_cnt", scnt, 1);
      chk("t7_poll_snap0", s0, w0);
      repeat (5) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
